decade_cascade_ctrl: RTL

Run-control sequencer for a cascade of 7490-style decade (BCD) counter stages. It holds `DIGITS` BCD digits, gates their counting with a prescaled tick, and ripples the carry digit-to-digit. It runs start/stop/pause/clear commands through a four-state machine and stops or reloads at a programmable terminal count. It sits between the front-panel/command logic and the digit display path, and it is the single owner of digit enables and clears.

---
 rtl/decade_cascade_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decade_cascade_ctrl.sv
// Run-control sequencer for a cascade of BCD decade counter stages.
// Define DECADE_CASCADE_CTRL_AUTORELOAD_EN to reload to zero on terminal match instead of halting.
module decade_cascade_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   term,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  tick,
    output logic                  done,
    output logic                  wrap
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e          state_q;
    logic [W-1:0]    count_q;
    logic [W-1:0]    term_q;
    logic [PW-1:0]   presc_q;
    logic            tick_q;
    logic            done_q;
    logic            wrap_q;
    logic [W-1:0]    count_inc;
    logic [DIGITS:0] carry_chain;
    logic            match;
`ifdef DECADE_CASCADE_CTRL_AUTORELOAD_EN
    logic            reload_q;
`endif

    // Whole cascade settles in one cycle; carry out of the top digit means all-9s rollover.
    always_comb begin
        count_inc      = count_q;
        carry_chain    = '0;
        carry_chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_chain[i]) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                    carry_chain[i+1]    = 1'b1;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    // A non-BCD terminal digit can never equal an incremented digit, so it never matches.
    assign match = (count_inc == term_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            term_q   <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef DECADE_CASCADE_CTRL_AUTORELOAD_EN
            reload_q <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (clear) begin
                state_q  <= StIdle;
                count_q  <= '0;
                presc_q  <= '0;
`ifdef DECADE_CASCADE_CTRL_AUTORELOAD_EN
                reload_q <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (stop) begin
                            state_q <= StIdle;
                        end else if (start) begin
                            term_q   <= term;
                            count_q  <= '0;
                            presc_q  <= '0;
                            state_q  <= StRun;
`ifdef DECADE_CASCADE_CTRL_AUTORELOAD_EN
                            reload_q <= 1'b0;
`endif
                        end
                    end
                    StRun: begin
                        if (stop) begin
                            state_q <= StPause;
                        end else if (presc_q == PLAST) begin
                            presc_q <= '0;
                            tick_q  <= 1'b1;
`ifdef DECADE_CASCADE_CTRL_AUTORELOAD_EN
                            if (reload_q) begin
                                count_q  <= '0;
                                reload_q <= 1'b0;
                            end else begin
                                count_q <= count_inc;
                                wrap_q  <= carry_chain[DIGITS];
                                if (match) begin
                                    done_q   <= 1'b1;
                                    reload_q <= 1'b1;
                                end
                            end
`else
                            count_q <= count_inc;
                            wrap_q  <= carry_chain[DIGITS];
                            if (match) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end
`endif
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    StPause: begin
                        if (stop) begin
                            state_q <= StIdle;
                        end else if (start) begin
                            state_q <= StRun;
                        end
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule
